// File: rtl/apb_pkg.sv
// Shared constants and FSM encodings for the APB register slave.
package apb_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_WAIT_CYCLES = 1;
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_if.sv
// APB bus bundle as seen by the slave; i_/o_ prefixes are from the slave side.
interface apb_slave_if #(
  parameter int WIDTH = apb_pkg::DEFAULT_WIDTH
);
  logic             i_PSEL;
  logic             i_PENABLE;
  logic             i_PWRITE;
  logic [WIDTH-1:0] i_PADDR;
  logic [WIDTH-1:0] i_PWDATA;
  logic [WIDTH-1:0] o_PRDATA;
  logic             o_PREADY;
  logic             o_PSLVERR;

  modport slave (
    input  i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
    output o_PRDATA, o_PREADY, o_PSLVERR
  );

  modport master (
    output i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
    input  o_PRDATA, o_PREADY, o_PSLVERR
  );
endinterface

// File: rtl/apb_regfile.sv
// DEPTH x WIDTH register storage: one synchronous write port, one combinational read port.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave.sv
// APB register slave with configurable wait states. Define APB_SLAVE_PSLVERR_EN
// to flag out-of-range addresses on o_PSLVERR.
//   state    | meaning
//   ST_IDLE  | waiting for a setup phase
//   ST_WAIT  | inserting wait states, counter running
//   ST_READY | o_PREADY high, transfer completes on PENABLE
module apb_slave
  import apb_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        i_PCLK,
  input  logic        i_PRESET,
  apb_slave_if.slave  s_apb
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [WIDTH:0]   DEPTH_W  = (WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  apb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_write;
  logic [WIDTH-1:0] r_prdata;
  logic             r_pready;
  logic             r_pslverr;

  logic [WIDTH-1:0] w_lkp_addr;
  logic             w_lkp_write;
  logic             w_in_range;
  logic             w_err;
  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] w_rd_value;
  logic             w_setup;
  logic             w_access;
  logic             w_we;

  assign w_setup  = s_apb.i_PSEL & ~s_apb.i_PENABLE;
  assign w_access = s_apb.i_PSEL &  s_apb.i_PENABLE;

  // With zero wait states READY is entered from IDLE, before the capture lands.
  assign w_lkp_addr  = (r_state == ST_IDLE) ? s_apb.i_PADDR  : r_addr;
  assign w_lkp_write = (r_state == ST_IDLE) ? s_apb.i_PWRITE : r_write;
  assign w_in_range  = ({1'b0, w_lkp_addr} < DEPTH_W);
  assign w_rd_value  = w_in_range ? w_rdata : '0;

`ifdef APB_SLAVE_PSLVERR_EN
  assign w_err = ~w_in_range;
`else
  assign w_err = 1'b0;
`endif

  assign w_we = (r_state == ST_READY) & w_access & r_write & w_in_range;

  apb_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .i_clk   (i_PCLK),
    .i_rst   (i_PRESET),
    .i_we    (w_we),
    .i_waddr (r_addr[AW-1:0]),
    .i_wdata (r_wdata),
    .i_raddr (w_lkp_addr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (w_setup) begin
            r_addr  <= s_apb.i_PADDR;
            r_wdata <= s_apb.i_PWDATA;
            r_write <= s_apb.i_PWRITE;
            r_cnt   <= '0;
            if (WAIT_CYCLES == 0) begin
              r_state   <= ST_READY;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              if (!w_lkp_write) r_prdata <= w_rd_value;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!s_apb.i_PSEL) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_READY;
            r_cnt     <= '0;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            if (!w_lkp_write) r_prdata <= w_rd_value;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          // Completion and abort both leave READY; the write port handles the commit.
          if (!s_apb.i_PSEL || s_apb.i_PENABLE) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  assign s_apb.o_PRDATA  = r_prdata;
  assign s_apb.o_PREADY  = r_pready;
  assign s_apb.o_PSLVERR = r_pslverr;

endmodule
